// File: rtl/lm07_bcd_converter.sv
// lm07_bcd_converter
// Exact signed binary-to-BCD conversion for the latched LM07/LM70 temperature,
// feeding the 7-segment decoder. Uses iterative shift-add-3 (double-dabble),
// one input bit per clock. Results are held stable between conversions so the
// display mux never sees intermediate scratch values.
//
// Parameters
//   IN_W    width of the two's-complement temperature input
//   DIGITS  number of BCD digits produced
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   temp_in     signed temperature, integer degrees
//   temp_valid  temp_in valid; accepted when temp_valid & temp_ready
//   temp_ready  converter idle, can accept a sample
//   bcd_out     BCD digits, [3:0]=ones, [7:4]=tens, [11:8]=hundreds ...
//   sign        1 = result is negative
//   overflow    1 = |temp_in| >= 10^DIGITS; bcd_out saturated to all 9s
//   done        one-cycle pulse: bcd_out/sign/overflow just updated
module lm07_bcd_converter #(
  parameter int unsigned IN_W   = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       temp_in,
  input  logic                  temp_valid,
  output logic                  temp_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state;
  logic [BcdW-1:0]   scratch;
  logic [IN_W-1:0]   mag;
  logic              neg;
  logic              ovf_flag;
  logic [CntW-1:0]   cnt;
  logic [BcdW-1:0]   adj;

  // Add-3 correction per digit, no inter-digit carry: with correct shifting a
  // digit is at most 9 here, so +3 never leaves its nibble.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      scratch    <= '0;
      mag        <= '0;
      neg        <= 1'b0;
      ovf_flag   <= 1'b0;
      cnt        <= '0;
      temp_ready <= 1'b1;
      bcd_out    <= '0;
      sign       <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (temp_valid) begin
            neg        <= temp_in[IN_W-1];
            // Negate as unsigned so the most negative input yields 2^(IN_W-1).
            mag        <= temp_in[IN_W-1] ? -temp_in : temp_in;
            scratch    <= '0;
            ovf_flag   <= 1'b0;
            cnt        <= CntW'(IN_W - 1);
            temp_ready <= 1'b0;
            state      <= StConv;
          end
        end
        StConv: begin
          scratch <= {adj[BcdW-2:0], mag[IN_W-1]};
          mag     <= {mag[IN_W-2:0], 1'b0};
          // A set MSB in the corrected top digit is a carry out of the BCD range.
          if (adj[BcdW-1]) begin
            ovf_flag <= 1'b1;
          end
          cnt <= cnt - CntW'(1);
          if (cnt == '0) begin
            state <= StDone;
          end
        end
        StDone: begin
          sign       <= neg;
          overflow   <= ovf_flag;
          bcd_out    <= ovf_flag ? {DIGITS{4'h9}} : scratch;
          done       <= 1'b1;
          temp_ready <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          state      <= StIdle;
          temp_ready <= 1'b1;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
